// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle EX-stage ALU with valid/ready handshake; shifts iterate one bit per cycle.
// Define ALU_SEQ_FAST_SHIFT_EN to use a single-cycle barrel shifter instead.
module alu_seq_exec #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_WIDTH-1:0] alu, sh_nxt;
  logic accept, go_shift, last;
  assign shamt = SrcB[SHAMT_W-1:0];
  assign accept = state == IDLE && in_valid;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    alu = '0;
    case (Operation)
      4'b0000: alu = SrcA & SrcB;
      4'b0001: alu = SrcA | SrcB;
      4'b0010: alu = SrcA + SrcB;
      4'b0011: alu = SrcA ^ SrcB;
`ifdef ALU_SEQ_FAST_SHIFT_EN
      4'b0100: alu = SrcA << shamt;
      4'b0101: alu = SrcA >> shamt;
      4'b0111: alu = $unsigned($signed(SrcA) >>> shamt);
`else
      // only a zero-amount shift lands here; nonzero amounts take the iterative path
      4'b0100, 4'b0101, 4'b0111: alu = SrcA;
`endif
      4'b1000: alu = SrcA - SrcB;
      4'b1100: alu = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      default: alu = '0;
    endcase
  end
`ifdef ALU_SEQ_FAST_SHIFT_EN
  assign go_shift = 1'b0;
  assign last = 1'b0;
  assign sh_nxt = '0;
`else
  logic [DATA_WIDTH-1:0] sh;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0] kind;
  assign go_shift = Operation[3:2] == 2'b01 && Operation[1:0] != 2'b10 && shamt != '0;
  assign last = state == SHIFT && cnt == SHAMT_W'(1);
  // kind is the latched Operation[1:0]: 00 SLL, 01 SRL, 11 SRA (MSB refills with the sign)
  assign sh_nxt = kind == 2'b00 ? {sh[DATA_WIDTH-2:0], 1'b0} : {kind[1] & sh[DATA_WIDTH-1], sh[DATA_WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      cnt <= '0;
      kind <= '0;
    end else if (accept && go_shift) begin
      sh <= SrcA;
      cnt <= shamt;
      kind <= Operation[1:0];
    end else if (state == SHIFT) begin
      sh <= sh_nxt;
      cnt <= cnt - SHAMT_W'(1);
    end
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = go_shift ? SHIFT : DONE;
      SHIFT: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult <= '0;
      Zero <= 1'b0;
    end else if (accept && !go_shift) begin
      ALUResult <= alu;
      Zero <= alu == '0;
    end else if (last) begin
      ALUResult <= sh_nxt;
      Zero <= sh_nxt == '0;
    end
  end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed vectors for alu_seq_exec checked against a behavioural model.
module tb_alu_seq_exec;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [3:0] Operation = 0;
  logic [31:0] SrcA = 0, SrcB = 0;
  logic in_ready, out_valid, Zero;
  logic [31:0] ALUResult;
  logic [31:0] exp_res = 0;
  logic exp_zero = 0;
  int errors = 0, checks = 0;

  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    int n;
    sa = a;
    n = int'(b[4:0]);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a ^ b;
      4'h4: return a << n;
      4'h5: return a >> n;
      4'h7: return sa >>> n;
      4'h8: return a - b;
      4'hC: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 1;
`else
    return (op == 4'h4 || op == 4'h5 || op == 4'h7) ? int'(b[4:0]) + 1 : 1;
`endif
  endfunction

  // checks every DONE cycle: result/flag against the model, unit busy
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("mon_result", ALUResult, exp_res);
      chk("mon_zero", {31'b0, Zero}, {31'b0, exp_zero});
      chk("mon_in_ready", {31'b0, in_ready}, 32'd0);
    end
  end

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit, input int hold, input bit poke);
    int n;
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1; out_ready = 0;
    @(posedge clk);
    exp_res = model(op, a, b);
    exp_zero = exp_res == 0;
    #1;
    in_valid = 0; Operation = 4'h2; SrcA = $urandom; SrcB = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    chk("latency", n, lat(op, b));
    chk("literal_result", ALUResult, lit);
    if (poke) begin
      Operation = 4'h2; SrcA = 1; SrcB = 1; in_valid = 1;
    end
    repeat (hold) @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("after_handshake", {30'b0, out_valid, in_ready}, 32'd1);
    in_valid = 0;
  endtask

  initial begin
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", {31'b0, Zero}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    run(4'h2, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0);
    run(4'h8, 32'd7, 32'd7, 32'd0, 0, 0);
    run(4'hC, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0);
    run(4'hC, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0);
    run(4'h7, 32'h80000000, 32'd31, 32'hFFFFFFFF, 0, 0);
    run(4'h5, 32'h80000000, 32'd31, 32'h00000001, 0, 0);
    run(4'h4, 32'd1, 32'd0, 32'd1, 0, 0);
    run(4'hF, 32'h1234, 32'h5678, 32'd0, 0, 0);
    run(4'h6, 32'hFFFF, 32'd3, 32'd0, 0, 0);
    run(4'h4, 32'd1, 32'h25, 32'h20, 0, 0);
    run(4'h0, 32'hF0F0, 32'h0FF0, 32'h00F0, 0, 0);
    run(4'h1, 32'hF0F0, 32'h0FF0, 32'hFFF0, 2, 0);
    run(4'h8, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 0);
    run(4'h7, 32'h40000000, 32'd4, 32'h04000000, 0, 0);
    run(4'h3, 32'hF0F0, 32'h0FF0, 32'hFF00, 10, 1);
    // reset in the middle of a long shift
    @(negedge clk);
    Operation = 4'h4; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1;
    @(posedge clk);
    exp_res = model(4'h4, 32'd1, 32'd20);
    exp_zero = exp_res == 0;
    #1 in_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", ALUResult, 32'd0);
    chk("midrst_zero", {31'b0, Zero}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    run(4'h2, 32'd2, 32'd3, 32'd5, 0, 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
